// File: rtl/axi_slave_mem_lat.sv
// rtl/axi_slave_mem_lat.sv - AXI4 slave word memory with independent read/write FSMs and configurable read latency
// FIXED/INCR/WRAP bursts, per-beat range decode (DECERR), WLAST/WRAP-length checks (SLVERR).

module axi_slave_mem_lat #(
    parameter int          ID_WIDTH   = 4,
    parameter int          DATA_WIDTH = 64,
    parameter int          MEM_WORDS  = 4096,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [31:0]             S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic [1:0]              S_AXI_AWBURST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]              S_AXI_BRESP,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [31:0]             S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic [1:0]              S_AXI_ARBURST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_RID,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST
);

    localparam int          BYTES     = DATA_WIDTH / 8;
    localparam int          LSB       = $clog2(BYTES);
    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam int          LAT_W     = 4;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS * BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] a33;
        a33 = {1'b0, a};
        return (a33 >= {1'b0, BASE_ADDR}) && (a33 < ({1'b0, BASE_ADDR} + MEM_BYTES));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> LSB);
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Unsupported WRAP lengths fall back to INCR stepping; the error is flagged separately.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [31:0] inc;
        logic [31:0] mask;
        inc  = a + 32'(BYTES);
        mask = (({24'd0, len} + 32'd1) << LSB) - 32'd1;
        if (burst == 2'b00)
            return a;
        if (burst == 2'b10 && wrap_len_ok(len))
            return (a & ~mask) | (inc & mask);
        return inc;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic                  rdy_en_q;
    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [31:0]           w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic                  w_slverr_q, w_slverr_d;
    logic                  w_decerr_q, w_decerr_d;
    logic                  mem_we;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [31:0]           r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic [LAT_W-1:0]      r_lat_q, r_lat_d;
    logic                  r_badwrap_q, r_badwrap_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic                  r_last_q, r_last_d;

    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      r_idx;

    assign w_idx = word_idx(w_addr_q);
    assign r_idx = word_idx(r_addr_q);

    assign S_AXI_AWREADY = rdy_en_q && (w_state_q == W_IDLE);
    assign S_AXI_WREADY  = (w_state_q == W_DATA);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BID     = w_id_q;
    assign S_AXI_BRESP   = w_decerr_q ? RESP_DECERR : (w_slverr_q ? RESP_SLVERR : RESP_OKAY);

    assign S_AXI_ARREADY = rdy_en_q && (r_state_q == R_IDLE);
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_RID     = r_id_q;
    assign S_AXI_RDATA   = r_data_q;
    assign S_AXI_RRESP   = r_resp_q;
    assign S_AXI_RLAST   = r_last_q && (r_state_q == R_DATA);

    always_comb begin
        w_state_d  = w_state_q;
        w_id_d     = w_id_q;
        w_addr_d   = w_addr_q;
        w_len_d    = w_len_q;
        w_burst_d  = w_burst_q;
        w_cnt_d    = w_cnt_q;
        w_slverr_d = w_slverr_q;
        w_decerr_d = w_decerr_q;
        mem_we     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                    w_id_d     = S_AXI_AWID;
                    w_addr_d   = S_AXI_AWADDR;
                    w_len_d    = S_AXI_AWLEN;
                    w_burst_d  = S_AXI_AWBURST;
                    w_cnt_d    = 8'd0;
                    w_slverr_d = (S_AXI_AWBURST == 2'b10) && !wrap_len_ok(S_AXI_AWLEN);
                    w_decerr_d = 1'b0;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID) begin
                    if (in_range(w_addr_q))
                        mem_we = 1'b1;
                    else
                        w_decerr_d = 1'b1;
                    // Burst length comes from AWLEN; WLAST is only cross-checked.
                    if (S_AXI_WLAST != (w_cnt_q == w_len_q))
                        w_slverr_d = 1'b1;
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d  = w_cnt_q + 8'd1;
                        w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d   = r_state_q;
        r_id_d      = r_id_q;
        r_addr_d    = r_addr_q;
        r_len_d     = r_len_q;
        r_burst_d   = r_burst_q;
        r_cnt_d     = r_cnt_q;
        r_lat_d     = r_lat_q;
        r_badwrap_d = r_badwrap_q;
        r_data_d    = r_data_q;
        r_resp_d    = r_resp_q;
        r_last_d    = r_last_q;
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                    r_id_d      = S_AXI_ARID;
                    r_addr_d    = S_AXI_ARADDR;
                    r_len_d     = S_AXI_ARLEN;
                    r_burst_d   = S_AXI_ARBURST;
                    r_cnt_d     = 8'd0;
                    r_lat_d     = '0;
                    r_badwrap_d = (S_AXI_ARBURST == 2'b10) && !wrap_len_ok(S_AXI_ARLEN);
                    r_state_d   = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_lat_q == LAT_W'(RD_LATENCY - 1)) begin
                    // Sampled with the pre-edge array contents, so a same-cycle write is not seen.
                    if (in_range(r_addr_q)) begin
                        r_data_d = mem_q[r_idx];
                        r_resp_d = r_badwrap_q ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        r_data_d = '0;
                        r_resp_d = RESP_DECERR;
                    end
                    r_last_d  = (r_cnt_q == r_len_q);
                    r_state_d = R_DATA;
                end else begin
                    r_lat_d = r_lat_q + LAT_W'(1);
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    if (r_last_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_addr_d  = next_addr(r_addr_q, r_len_q, r_burst_q);
                        r_lat_d   = '0;
                        r_state_d = R_WAIT;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rdy_en_q    <= 1'b0;
            w_state_q   <= W_IDLE;
            w_id_q      <= '0;
            w_addr_q    <= '0;
            w_len_q     <= '0;
            w_burst_q   <= '0;
            w_cnt_q     <= '0;
            w_slverr_q  <= 1'b0;
            w_decerr_q  <= 1'b0;
            r_state_q   <= R_IDLE;
            r_id_q      <= '0;
            r_addr_q    <= '0;
            r_len_q     <= '0;
            r_burst_q   <= '0;
            r_cnt_q     <= '0;
            r_lat_q     <= '0;
            r_badwrap_q <= 1'b0;
            r_data_q    <= '0;
            r_resp_q    <= '0;
            r_last_q    <= 1'b0;
        end else begin
            rdy_en_q    <= 1'b1;
            w_state_q   <= w_state_d;
            w_id_q      <= w_id_d;
            w_addr_q    <= w_addr_d;
            w_len_q     <= w_len_d;
            w_burst_q   <= w_burst_d;
            w_cnt_q     <= w_cnt_d;
            w_slverr_q  <= w_slverr_d;
            w_decerr_q  <= w_decerr_d;
            r_state_q   <= r_state_d;
            r_id_q      <= r_id_d;
            r_addr_q    <= r_addr_d;
            r_len_q     <= r_len_d;
            r_burst_q   <= r_burst_d;
            r_cnt_q     <= r_cnt_d;
            r_lat_q     <= r_lat_d;
            r_badwrap_q <= r_badwrap_d;
            r_data_q    <= r_data_d;
            r_resp_q    <= r_resp_d;
            r_last_q    <= r_last_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (S_AXI_WSTRB[b])
                    mem_q[w_idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem_lat.sv
// tb/tb_axi_slave_mem_lat.sv - scoreboard bench for axi_slave_mem_lat
// Expected B/R responses come from a bench-side word model and are queued at stimulus time.

module tb_axi_slave_mem_lat;

    localparam int          RDL  = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [63:0] wdata, rdata;
    logic        arvalid, arready, rvalid, rready, rlast;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
    rbeat_t      rq[$];
    bexp_t       bq[$];
    logic [63:0] model [int];

    axi_slave_mem_lat #(.ID_WIDTH(4), .DATA_WIDTH(64), .MEM_WORDS(4096),
                        .RD_LATENCY(RDL), .BASE_ADDR(BASE)) dut (
        .S_AXI_ACLK(clk),        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWID(awid),
        .S_AXI_AWADDR(awaddr),   .S_AXI_AWLEN(awlen),     .S_AXI_AWBURST(awburst),
        .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),   .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),     .S_AXI_WLAST(wlast),
        .S_AXI_BVALID(bvalid),   .S_AXI_BREADY(bready),   .S_AXI_BID(bid), .S_AXI_BRESP(bresp),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARID(arid),
        .S_AXI_ARADDR(araddr),   .S_AXI_ARLEN(arlen),     .S_AXI_ARBURST(arburst),
        .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready),   .S_AXI_RID(rid),
        .S_AXI_RDATA(rdata),     .S_AXI_RRESP(rresp),     .S_AXI_RLAST(rlast)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        longint la;
        la = longint'({32'd0, a});
        return (la >= longint'({32'd0, BASE})) && (la < longint'({32'd0, BASE}) + 64'sd32768);
    endfunction

    function automatic logic wrap_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [7:0] len,
                                        input logic [1:0] burst);
        logic [31:0] mask;
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && wrap_ok(len)) begin
            mask = (32'(len) + 32'd1) * 32'd8 - 32'd1;
            return (a & ~mask) | ((a + 32'd8) & mask);
        end
        return a + 32'd8;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    // Called at a negedge; returns at a negedge after the B handshake.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [63:0] dbase,
                            input logic [7:0] strb, input int wlast_at);
        logic [31:0] a;
        logic        slv, dec, wl;
        logic [63:0] w, d;
        int          t, idx;
        bexp_t       e;
        a   = addr;
        slv = (burst == 2'b10) && !wrap_ok(len);
        dec = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wl = (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at);
            if (wl != (i == int'(len))) slv = 1'b1;
            d = dbase + 64'(i);
            if (in_rng(a)) begin
                idx = widx(a);
                w = model.exists(idx) ? model[idx] : 64'd0;
                for (int b = 0; b < 8; b++)
                    if (strb[b]) w[b*8 +: 8] = d[b*8 +: 8];
                model[idx] = w;
            end else begin
                dec = 1'b1;
            end
            a = nxt(a, len, burst);
        end
        e.id   = id;
        e.resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
        bq.push_back(e);

        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awburst = burst;
        t = 0;
        while (!awready && t < 200) begin @(negedge clk); t++; end
        check("aw_ready", 64'(awready), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wdata  = dbase + 64'(i);
            wstrb  = strb;
            wlast  = (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at);
            t = 0;
            while (!wready && t < 200) begin @(negedge clk); t++; end
            check("w_ready", 64'(wready), 64'd1);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        t = 0;
        while (!bvalid && t < 200) begin @(negedge clk); t++; end
        check("b_valid", 64'(bvalid), 64'd1);
        e = bq.pop_front();
        check("bid", 64'(bid), 64'(e.id));
        check("bresp", 64'(bresp), 64'(e.resp));
        @(negedge clk);
        check("b_done", 64'(bvalid), 64'd0);
    endtask

    // Called at a negedge; toggle makes RREADY alternate every cycle.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic toggle);
        logic [31:0] a;
        logic        bad, rr, first, stalled;
        int          t, lat, beats, idx;
        rbeat_t      e, held;
        a   = addr;
        bad = (burst == 2'b10) && !wrap_ok(len);
        for (int i = 0; i <= int'(len); i++) begin
            idx    = widx(a);
            e.id   = id;
            e.last = (i == int'(len));
            if (in_rng(a)) begin
                e.data = model.exists(idx) ? model[idx] : 64'd0;
                e.resp = bad ? 2'b10 : 2'b00;
            end else begin
                e.data = 64'd0;
                e.resp = 2'b11;
            end
            rq.push_back(e);
            a = nxt(a, len, burst);
        end

        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arburst = burst;
        t = 0;
        while (!arready && t < 200) begin @(negedge clk); t++; end
        check("ar_ready", 64'(arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1; beats = 0; t = 0; first = 1'b1; stalled = 1'b0; rr = 1'b1;
        held = '{default: '0};
        while (beats <= int'(len) && t < 500) begin
            rr     = toggle ? !rr : 1'b1;
            rready = rr;
            if (rvalid) begin
                if (first) begin
                    check("r_latency", 64'(lat), 64'(RDL + 1));
                    first = 1'b0;
                end
                if (stalled) begin
                    check("r_hold_data", rdata, held.data);
                    check("r_hold_resp", 64'(rresp), 64'(held.resp));
                    check("r_hold_last", 64'(rlast), 64'(held.last));
                end
                if (rr) begin
                    e = rq.pop_front();
                    check("rdata", rdata, e.data);
                    check("rresp", 64'(rresp), 64'(e.resp));
                    check("rlast", 64'(rlast), 64'(e.last));
                    check("rid", 64'(rid), 64'(e.id));
                    beats++;
                    stalled = 1'b0;
                end else begin
                    held.data = rdata; held.resp = rresp; held.last = rlast;
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            t++; lat++;
        end
        rready = 1'b1;
        check("r_beats", 64'(beats), 64'(int'(len) + 1));
        check("r_done", 64'(rvalid), 64'd0);
    endtask

    int tt;

    initial begin
        rst_n = 1'b0;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1'b1;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arburst = 0; rready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rlast", 64'(rlast), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_bresp", 64'(bresp), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_awready_0", 64'(awready), 64'd0);
        @(negedge clk);
        check("rel_awready_1", 64'(awready), 64'd1);
        check("rel_arready_1", 64'(arready), 64'd1);

        do_write(4'd5, BASE, 8'd3, 2'b01, 64'd1, 8'hFF, -1);
        do_read(4'd9, BASE, 8'd3, 2'b01, 1'b0);

        do_write(4'd2, BASE, 8'd7, 2'b01, 64'h100, 8'hFF, -1);
        do_write(4'd3, BASE + 32'h8, 8'd1, 2'b00, 64'hDEAD_BEEF_CAFE_0000, 8'h0F, -1);
        do_read(4'd4, BASE + 32'h18, 8'd3, 2'b10, 1'b0);
        do_read(4'd6, BASE + 32'h18, 8'd2, 2'b10, 1'b0);

        do_write(4'd7, BASE + 32'h7FF8, 8'd1, 2'b01, 64'hA5A5_0000_0000_0001, 8'hFF, -1);
        do_read(4'd8, BASE + 32'h7FF8, 8'd1, 2'b01, 1'b0);
        do_read(4'd1, 32'h0000_1000, 8'd0, 2'b01, 1'b0);

        fork
            do_write(4'd10, BASE + 32'h100, 8'd3, 2'b01, 64'h5000, 8'hFF, -1);
            do_read(4'd11, BASE, 8'd3, 2'b01, 1'b1);
        join
        do_read(4'd12, BASE + 32'h100, 8'd3, 2'b01, 1'b1);

        do_write(4'd13, BASE + 32'h200, 8'd3, 2'b01, 64'h7000, 8'hFF, 1);
        do_read(4'd14, BASE + 32'h200, 8'd3, 2'b01, 1'b0);

        rready = 1'b0;
        arvalid = 1'b1; arid = 4'd3; araddr = BASE; arlen = 8'd7; arburst = 2'b01;
        tt = 0;
        while (!arready && tt < 100) begin @(negedge clk); tt++; end
        @(negedge clk);
        arvalid = 1'b0;
        tt = 0;
        while (!rvalid && tt < 100) begin @(negedge clk); tt++; end
        check("mr_rvalid_pre", 64'(rvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_rvalid_rst", 64'(rvalid), 64'd0);
        check("mr_rdata_rst", rdata, 64'd0);
        check("mr_arready_rst", 64'(arready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_arready_rel0", 64'(arready), 64'd0);
        @(negedge clk);
        check("mr_arready_rel1", 64'(arready), 64'd1);
        rready = 1'b1;
        do_read(4'd15, BASE, 8'd0, 2'b01, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
